// File: rtl/alu_ex_stage.sv
// alu_ex_stage: execute stage around an external combinational 32-bit ALU.
//   Stage 1 holds one operand set from decode and drives the ALU directly.
//   The ALU response (or an illegal-op marker) is written into a 2-entry
//   FIFO whose head is presented to writeback. One op per cycle sustained.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               decode handshake
//   in_a, in_b, in_op, in_tag       operands, ALUop, destination tag
//   alu_a, alu_b, alu_op            to ALU (straight from stage-1 register)
//   alu_result/ovf/cout/zero        from ALU
//   out_valid/out_ready             writeback handshake (FIFO head)
//   out_result, out_flags, out_tag  head entry; flags = {illegal,ovf,cout,zero}
//   trap_valid, trap_tag            overflow trap pulse
// Build option: define ALU_EX_OVF_TRAP_EN to divert overflowing ADD/SUB to a
//   one-cycle trap pulse instead of the FIFO. Undefined: trap outputs are 0.
module alu_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [2:0]            in_op,
  input  logic [TAG_W-1:0]      in_tag,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_ovf,
  input  logic                  alu_cout,
  input  logic                  alu_zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [3:0]            out_flags,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  trap_valid,
  output logic [TAG_W-1:0]      trap_tag
);
  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010,
                         OP_SUB = 3'b110, OP_SLT = 3'b111;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] res;
    logic [3:0]            flags;
    logic [TAG_W-1:0]      tag;
  } entry_t;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]            op_q, op_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  entry_t                mem_q [2];
  entry_t                mem_d [2];
  entry_t                wr_entry;
  logic                  pop, push, s1_adv, accept, legal, arith, trap;

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign out_valid  = (cnt_q != 2'd0);
  assign out_result = mem_q[rd_ptr_q].res;
  assign out_flags  = mem_q[rd_ptr_q].flags;
  assign out_tag    = mem_q[rd_ptr_q].tag;

  always_comb begin
    pop      = out_valid & out_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still advances.
    s1_adv   = s1_valid_q & ((cnt_q != 2'd2) | pop);
    in_ready = ~s1_valid_q | s1_adv;
    accept   = in_valid & in_ready;

    legal = (op_q == OP_AND) | (op_q == OP_OR) | (op_q == OP_ADD) |
            (op_q == OP_SUB) | (op_q == OP_SLT);
    arith = (op_q == OP_ADD) | (op_q == OP_SUB);

    wr_entry.tag = tag_q;
    if (!legal) begin
      wr_entry.res   = '0;
      wr_entry.flags = 4'b1001;
    end else begin
      // Only ADD/SUB carry meaningful overflow/carry out of the ALU.
      wr_entry.res   = alu_result;
      wr_entry.flags = {1'b0, arith & alu_ovf, arith & alu_cout, alu_zero};
    end

`ifdef ALU_EX_OVF_TRAP_EN
    trap = s1_adv & legal & arith & alu_ovf;
`else
    trap = 1'b0;
`endif
    push = s1_adv & ~trap;

    a_d = a_q; b_d = b_q; op_d = op_q; tag_d = tag_q;
    if (accept) begin
      a_d = in_a; b_d = in_b; op_d = in_op; tag_d = in_tag;
    end
    s1_valid_d = accept ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_entry;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tag_q      <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      for (int i = 0; i < 2; i++) mem_q[i] <= mem_d[i];
    end
  end

`ifdef ALU_EX_OVF_TRAP_EN
  logic             trap_valid_q, trap_valid_d;
  logic [TAG_W-1:0] trap_tag_q, trap_tag_d;

  always_comb begin
    trap_valid_d = trap;
    trap_tag_d   = trap ? tag_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_valid_q <= 1'b0;
      trap_tag_q   <= '0;
    end else begin
      trap_valid_q <= trap_valid_d;
      trap_tag_q   <= trap_tag_d;
    end
  end

  assign trap_valid = trap_valid_q;
  assign trap_tag   = trap_tag_q;
`else
  assign trap_valid = 1'b0;
  assign trap_tag   = '0;
`endif
endmodule

// File: tb/tb_alu_ex_stage.sv
module tb_alu_ex_stage;
  localparam int DW = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_a, in_b;
  logic [2:0]    in_op;
  logic [TW-1:0] in_tag;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [2:0]    alu_op;
  logic          alu_ovf, alu_cout, alu_zero;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_result;
  logic [3:0]    out_flags;
  logic [TW-1:0] out_tag;
  logic          trap_valid;
  logic [TW-1:0] trap_tag;

  alu_ex_stage #(.DATA_WIDTH(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_ovf(alu_ovf), .alu_cout(alu_cout), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag),
    .trap_valid(trap_valid), .trap_tag(trap_tag)
  );

  always #5 clk = ~clk;

  // External ALU. Non-arithmetic ops report ovf/cout=1 on purpose: the stage
  // must mask them. Unlisted ops return garbage the stage must ignore.
  logic [32:0] alu_t;
  always_comb begin
    alu_t = '0; alu_result = '0; alu_ovf = 1'b1; alu_cout = 1'b1;
    case (alu_op)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: begin
        alu_t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = alu_t[31:0];
        alu_cout = alu_t[32];
        alu_ovf = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      3'b110: begin
        alu_result = alu_a - alu_b;
        alu_cout = alu_a < alu_b;
        alu_ovf = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      3'b111: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = 32'hDEADBEEF;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    logic [DW-1:0] res;
    logic [3:0]    fl;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          exp_q[$];
  logic [TW-1:0] trap_q[$];
  int            n_chk = 0, n_fail = 0;
  int            or_mode = 1;  // 0 hold, 1 always ready, 2 random
  logic [DW-1:0] corners[6] = '{32'h7FFFFFFF, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE};

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: operations evaluated with wide signed/unsigned integer arithmetic.
  function automatic void model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [2:0] op, input logic [TW-1:0] tag,
                                output exp_t e, output bit trap);
    longint sa, sb, ua, ub, r;
    bit ovf, cout, legal;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'b0, a};           ub = {32'b0, b};
    ovf = 0; cout = 0; legal = 1; r = 0;
    case (op)
      3'd0: r = ua & ub;
      3'd1: r = ua | ub;
      3'd2: begin
        r = ua + ub; cout = r[32];
        ovf = (sa + sb) != longint'($signed(r[31:0]));
      end
      3'd6: begin
        r = ua - ub; cout = ua < ub;
        ovf = (sa - sb) != longint'($signed(r[31:0]));
      end
      3'd7: r = (sa < sb) ? 1 : 0;
      default: legal = 0;
    endcase
    e.tag = tag;
    if (!legal) begin
      e.res = '0; e.fl = 4'b1001;
    end else begin
      e.res = r[31:0]; e.fl = {1'b0, ovf, cout, r[31:0] == 0};
    end
`ifdef ALU_EX_OVF_TRAP_EN
    trap = legal && ovf;
`else
    trap = 0;
`endif
  endfunction

  // Present one op until accepted; the expectation is queued at acceptance.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] op,
                      input logic [TW-1:0] tag, input exp_t e, input bit trap);
    int w = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
      #1;
      if (in_ready) begin
        if (trap) trap_q.push_back(tag); else exp_q.push_back(e);
        done = 1;
      end else if (++w > 200) begin
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        done = 1;
      end
    end
  endtask

  task automatic send_m(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [2:0] op, input logic [TW-1:0] tag);
    exp_t e; bit t;
    model(a, b, op, tag, e, t);
    send(a, b, op, tag, e, t);
  endtask

  task automatic send_x(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] op,
                        input logic [TW-1:0] tag, input logic [DW-1:0] r, input logic [3:0] f);
    exp_t e;
    e.res = r; e.fl = f; e.tag = tag;
    send(a, b, op, tag, e, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); in_valid = 1'b0; end
  endtask

  task automatic reset_checks(input string pfx);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_out_result"}, out_result, 0);
    chk({pfx, "_out_flags"}, out_flags, 0);
    chk({pfx, "_out_tag"}, out_tag, 0);
    chk({pfx, "_trap_valid"}, trap_valid, 0);
    chk({pfx, "_trap_tag"}, trap_tag, 0);
    chk({pfx, "_in_ready"}, in_ready, 1);
    chk({pfx, "_alu_op"}, alu_op, 0);
    chk({pfx, "_alu_ab"}, {alu_a, alu_b}, 0);
  endtask

  task automatic drain(input int budget);
    int w = 0;
    or_mode = 1;
    while ((exp_q.size() != 0 || trap_q.size() != 0) && w < budget) begin
      @(negedge clk); w++;
    end
    chk("drain_exp_left", exp_q.size(), 0);
    chk("drain_trap_left", trap_q.size(), 0);
  endtask

  // Monitor: output FIFO head, hold stability, trap pulses.
  logic          hold_prev = 1'b0;
  logic [DW-1:0] p_res;
  logic [3:0]    p_fl;
  logic [TW-1:0] p_tag;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (!rst_n) begin
        hold_prev = 1'b0;
        continue;
      end
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_stable", {out_result, out_flags, out_tag}, {p_res, p_fl, p_tag});
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          chk("out_result", out_result, e.res);
          chk("out_flags", out_flags, e.fl);
          chk("out_tag", out_tag, e.tag);
        end
      end
      hold_prev = out_valid & ~out_ready;
      p_res = out_result; p_fl = out_flags; p_tag = out_tag;
      if (trap_valid) begin
        if (trap_q.size() == 0) chk("spurious_trap", trap_valid, 0);
        else chk("trap_tag", trap_tag, trap_q.pop_front());
      end
    end
  end

  initial begin
    exp_t e;
    in_valid = 0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0; out_ready = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_checks("por");
    @(negedge clk); rst_n = 1'b1;

    // Overflowing ADD
    or_mode = 1;
`ifdef ALU_EX_OVF_TRAP_EN
    e.res = '0; e.fl = '0; e.tag = 5'd3;
    send(32'h7FFFFFFF, 32'h1, 3'b010, 5'd3, e, 1'b1);
`else
    send_x(32'h7FFFFFFF, 32'h1, 3'b010, 5'd3, 32'h80000000, 4'b0100);
`endif
    idle(1);
    drain(20);

    // SUB / SLT / AND back-to-back
    send_x(32'd5, 32'd7, 3'b110, 5'd4, 32'hFFFFFFFE, 4'b0010);
    send_x(32'hFFFFFFFF, 32'd1, 3'b111, 5'd5, 32'd1, 4'b0000);
    send_x(32'h0000F0F0, 32'h00000FF0, 3'b000, 5'd6, 32'h000000F0, 4'b0000);
    idle(1);
    drain(20);

    // Illegal op then legal op
    send_x(32'h12345678, 32'h9ABCDEF0, 3'b011, 5'd9, 32'd0, 4'b1001);
    send_x(32'h1, 32'h2, 3'b001, 5'd10, 32'd3, 4'b0000);
    idle(1);
    drain(20);

    // Backpressure: three ops fit, the fourth stalls until out_ready rises
    or_mode = 0;
    send_m(32'd10, 32'd20, 3'b010, 5'd11);
    send_m(32'd30, 32'd30, 3'b110, 5'd12);
    send_m(32'hFF00FF00, 32'h0F0F0F0F, 3'b001, 5'd13);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'd1; in_b = 32'd2; in_op = 3'b111; in_tag = 5'd14;
      #1 chk("bp_in_ready", in_ready, 0);
    end
    or_mode = 1;
    send_m(32'd1, 32'd2, 3'b111, 5'd14);
    idle(1);
    drain(20);

    // Mid-stream reset with three ops buffered
    or_mode = 0;
    send_m(32'd1, 32'd1, 3'b010, 5'd1);
    send_m(32'd2, 32'd2, 3'b010, 5'd2);
    send_m(32'd3, 32'd3, 3'b010, 5'd3);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #1 reset_checks("mid");
    exp_q.delete(); trap_q.delete();
    @(negedge clk); rst_n = 1'b1;
    or_mode = 1;

    // Random traffic
    or_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      logic [DW-1:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
      if ($urandom_range(0, 3) == 0) idle(1);
      send_m(a, b, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end
    idle(1);
    drain(200);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
